// File: rtl/ale_pkg.sv
// Shared types and constants for the frame-streaming atmospheric-light estimator.
// Used by ale_recip_div and ale_stream_estimator.
package ale_pkg;

   typedef enum logic [2:0] {IDLE, BLEND, DIV_R, DIV_G, DIV_B, DONE} ale_state_e;

   localparam int DW_DEF    = 8;
   localparam int INV_W_DEF = 16;

   // Channel slice index inside a pixel word (BMP order); bit offset is index*DW.
   localparam int CH_B = 0;
   localparam int CH_G = 1;
   localparam int CH_R = 2;

   function automatic logic [63:0] recip_num(input int inv_w);
      logic [64:0] one;
      one = 65'd1;
      return 64'((one << inv_w) - 65'd1);
   endfunction

endpackage

// File: rtl/ale_recip_div.sv
// Serial restoring divider: quotient = floor((2^INV_W-1)/divisor), one bit per cycle MSB-first.
// The start edge performs the first iteration, so done pulses INV_W cycles after start.
module ale_recip_div
   import ale_pkg::*;
#(
   parameter int DW    = DW_DEF,
   parameter int INV_W = INV_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [DW-1:0]    divisor,
   output logic             busy,
   output logic             done,
   output logic [INV_W-1:0] quotient
);

   localparam logic [INV_W-1:0] NUM = INV_W'(recip_num(INV_W));
   localparam int CW = $clog2(INV_W + 1);

   logic [DW-1:0]    d_q, rem_q, rem_nxt, d_in, rem_in;
   logic [INV_W-1:0] num_q;
   logic [CW-1:0]    cnt_q;
   logic [DW:0]      trial, diff;
   logic             bit_in, take;

   // A zero divisor makes every trial succeed, which saturates the quotient to all ones.
   always_comb begin
      d_in    = start ? divisor : d_q;
      rem_in  = start ? '0 : rem_q;
      bit_in  = start ? NUM[INV_W-1] : num_q[INV_W-1];
      trial   = {rem_in, bit_in};
      take    = (trial >= {1'b0, d_in});
      diff    = trial - {1'b0, d_in};
      rem_nxt = take ? diff[DW-1:0] : trial[DW-1:0];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         d_q      <= '0;
         rem_q    <= '0;
         num_q    <= '0;
         cnt_q    <= '0;
         quotient <= '0;
         done     <= 1'b0;
      end else begin
         done <= 1'b0;
         if (start) begin
            d_q      <= divisor;
            rem_q    <= rem_nxt;
            num_q    <= NUM << 1;
            quotient <= {{(INV_W-1){1'b0}}, take};
            cnt_q    <= CW'(INV_W - 1);
         end else if (cnt_q != '0) begin
            rem_q    <= rem_nxt;
            num_q    <= num_q << 1;
            quotient <= {quotient[INV_W-2:0], take};
            cnt_q    <= cnt_q - 1'b1;
            if (cnt_q == CW'(1)) done <= 1'b1;
         end
      end
   end

   assign busy = (cnt_q != '0);

endmodule

// File: rtl/ale_stream_estimator.sv
// Frame-streaming atmospheric-light estimator: max-of-min-channel pixel per frame, clamped,
// then three reciprocals from one shared serial divider. ALE_IIR_EN adds an IIR BLEND stage.
module ale_stream_estimator
   import ale_pkg::*;
#(
   parameter int DW          = DW_DEF,
   parameter int INV_W       = INV_W_DEF,
   parameter int IMG_W       = 512,
   parameter int IMG_H       = 512,
   parameter int A_MIN       = 1,
   parameter int ALPHA_SHIFT = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [3*DW-1:0]  input_pixel,
   input  logic             input_is_valid,
   output logic [DW-1:0]    a_r,
   output logic [DW-1:0]    a_g,
   output logic [DW-1:0]    a_b,
   output logic [INV_W-1:0] inv_a_r,
   output logic [INV_W-1:0] inv_a_g,
   output logic [INV_W-1:0] inv_a_b,
   output logic             ale_valid,
   output logic             busy,
   output logic             overrun
);

   localparam int NPIX  = IMG_W * IMG_H;
   localparam int CNT_W = (NPIX > 1) ? $clog2(NPIX) : 1;
   localparam logic [DW-1:0] AMIN_V = DW'(A_MIN);

   function automatic logic [DW-1:0] floor_a(input logic [DW-1:0] v);
      return (v < AMIN_V) ? AMIN_V : v;
   endfunction

   // prev + ((cand - prev) >>> ALPHA_SHIFT), signed DW+1 difference, clamped to [A_MIN, 2^DW-1].
   function automatic logic [DW-1:0] blend(input logic [DW-1:0] prev, input logic [DW-1:0] cand);
      logic signed [DW:0]   d;
      logic signed [DW+1:0] step, sum;
      d    = $signed({1'b0, cand}) - $signed({1'b0, prev});
      step = $signed({d[DW], d}) >>> ALPHA_SHIFT;
      sum  = $signed({2'b00, prev}) + step;
      if (sum[DW+1])                     return AMIN_V;
      else if (sum[DW])                  return '1;
      else if (sum[DW-1:0] < AMIN_V)     return AMIN_V;
      else                               return sum[DW-1:0];
   endfunction

   logic [DW-1:0]    pix_r, pix_g, pix_b, key;
   logic [CNT_W-1:0] pix_cnt;
   logic [DW-1:0]    best_key;
   logic [3*DW-1:0]  best_pix;
   logic             frame_end, frame_end_q;

   assign pix_b = input_pixel[CH_B*DW +: DW];
   assign pix_g = input_pixel[CH_G*DW +: DW];
   assign pix_r = input_pixel[CH_R*DW +: DW];

   always_comb begin
      key = pix_r;
      if (pix_g < key) key = pix_g;
      if (pix_b < key) key = pix_b;
   end

   assign frame_end = input_is_valid && (pix_cnt == CNT_W'(NPIX - 1));

   // Accumulation never stalls; the frame's own last pixel competes before best is handed off.
   always_ff @(posedge clk) begin
      if (rst) begin
         pix_cnt     <= '0;
         best_key    <= '0;
         best_pix    <= '0;
         frame_end_q <= 1'b0;
      end else begin
         frame_end_q <= frame_end;
         if (input_is_valid) begin
            pix_cnt <= frame_end ? '0 : pix_cnt + 1'b1;
            if ((pix_cnt == '0) || (key > best_key)) begin
               best_key <= key;
               best_pix <= input_pixel;
            end
         end
      end
   end

   ale_state_e state, state_nxt;
   logic       cand_vld, drop;
   logic [DW-1:0] cand_r, cand_g, cand_b;
   logic [DW-1:0] a_next_r, a_next_g, a_next_b;
   logic [DW-1:0] a_work_r, a_work_g, a_work_b;
   logic [INV_W-1:0] inv_w_r, inv_w_g, div_q;
   logic             div_start, div_busy, div_done;
   logic [DW-1:0]    div_divisor;

   assign drop = frame_end_q && ((state != IDLE) || cand_vld);

   always_ff @(posedge clk) begin
      if (rst) begin
         cand_r   <= '0;
         cand_g   <= '0;
         cand_b   <= '0;
         cand_vld <= 1'b0;
         overrun  <= 1'b0;
      end else begin
         cand_vld <= 1'b0;
         if (frame_end_q) begin
            if (drop) begin
               overrun <= 1'b1;
            end else begin
               cand_r   <= floor_a(best_pix[CH_R*DW +: DW]);
               cand_g   <= floor_a(best_pix[CH_G*DW +: DW]);
               cand_b   <= floor_a(best_pix[CH_B*DW +: DW]);
               cand_vld <= 1'b1;
            end
         end
      end
   end

`ifdef ALE_IIR_EN
   logic has_hist;

   always_comb begin
      a_next_r = has_hist ? blend(a_work_r, cand_r) : cand_r;
      a_next_g = has_hist ? blend(a_work_g, cand_g) : cand_g;
      a_next_b = has_hist ? blend(a_work_b, cand_b) : cand_b;
   end

   always_ff @(posedge clk) begin
      if (rst)                        has_hist <= 1'b0;
      else if (state == BLEND)        has_hist <= 1'b1;
   end
`else
   always_comb begin
      a_next_r = cand_r;
      a_next_g = cand_g;
      a_next_b = cand_b;
   end
`endif

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE: begin
            if (cand_vld) begin
`ifdef ALE_IIR_EN
               state_nxt = BLEND;
`else
               state_nxt = DIV_R;
`endif
            end
         end
         BLEND:   state_nxt = DIV_R;
         DIV_R:   if (div_done) state_nxt = DIV_G;
         DIV_G:   if (div_done) state_nxt = DIV_B;
         DIV_B:   if (div_done) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      ale_valid = (state == DONE);
      busy      = div_busy || (state inside {DIV_R, DIV_G, DIV_B, DONE});
   end

   // Each channel's division starts on the same edge the previous one hands over its quotient.
   always_comb begin
      div_start   = 1'b0;
      div_divisor = a_work_r;
      unique case (state)
         IDLE: begin
`ifndef ALE_IIR_EN
            div_start = cand_vld;
`endif
            div_divisor = a_next_r;
         end
         BLEND: begin
            div_start   = 1'b1;
            div_divisor = a_next_r;
         end
         DIV_R: begin
            div_start   = div_done;
            div_divisor = a_work_g;
         end
         DIV_G: begin
            div_start   = div_done;
            div_divisor = a_work_b;
         end
         default: ;
      endcase
   end

   ale_recip_div #(.DW(DW), .INV_W(INV_W)) u_div (
      .clk      (clk),
      .rst      (rst),
      .start    (div_start),
      .divisor  (div_divisor),
      .busy     (div_busy),
      .done     (div_done),
      .quotient (div_q)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         a_work_r <= '0;
         a_work_g <= '0;
         a_work_b <= '0;
         inv_w_r  <= '0;
         inv_w_g  <= '0;
         a_r      <= '0;
         a_g      <= '0;
         a_b      <= '0;
         inv_a_r  <= '0;
         inv_a_g  <= '0;
         inv_a_b  <= '0;
      end else begin
         if (div_start && ((state == IDLE) || (state == BLEND))) begin
            a_work_r <= a_next_r;
            a_work_g <= a_next_g;
            a_work_b <= a_next_b;
         end
         if ((state == DIV_R) && div_done) inv_w_r <= div_q;
         if ((state == DIV_G) && div_done) inv_w_g <= div_q;
         // Publish everything on the edge entering DONE so it lines up with ale_valid.
         if ((state == DIV_B) && div_done) begin
            a_r     <= a_work_r;
            a_g     <= a_work_g;
            a_b     <= a_work_b;
            inv_a_r <= inv_w_r;
            inv_a_g <= inv_w_g;
            inv_a_b <= div_q;
         end
      end
   end

endmodule

// File: tb/tb_ale_stream_estimator.sv
// Directed, table-driven bench for ale_stream_estimator (8x8 frames plus a 4x4 overrun instance).
`timescale 1ns/1ps
module tb_ale_stream_estimator;

`ifdef ALE_IIR_EN
   localparam int LAT = 51;
`else
   localparam int LAT = 50;
`endif

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic [23:0] pix, pix_s;
   logic        vld, vld_s;
   logic [7:0]  a_r, a_g, a_b, a_r_s, a_g_s, a_b_s;
   logic [15:0] inv_a_r, inv_a_g, inv_a_b, inv_a_r_s, inv_a_g_s, inv_a_b_s;
   logic        ale_valid, busy, overrun, ale_valid_s, busy_s, overrun_s;

   ale_stream_estimator #(.DW(8), .INV_W(16), .IMG_W(8), .IMG_H(8), .A_MIN(1), .ALPHA_SHIFT(1)) u_dut (
      .clk(clk), .rst(rst), .input_pixel(pix), .input_is_valid(vld),
      .a_r(a_r), .a_g(a_g), .a_b(a_b), .inv_a_r(inv_a_r), .inv_a_g(inv_a_g), .inv_a_b(inv_a_b),
      .ale_valid(ale_valid), .busy(busy), .overrun(overrun));

   ale_stream_estimator #(.DW(8), .INV_W(16), .IMG_W(4), .IMG_H(4), .A_MIN(1), .ALPHA_SHIFT(1)) u_small (
      .clk(clk), .rst(rst), .input_pixel(pix_s), .input_is_valid(vld_s),
      .a_r(a_r_s), .a_g(a_g_s), .a_b(a_b_s), .inv_a_r(inv_a_r_s), .inv_a_g(inv_a_g_s), .inv_a_b(inv_a_b_s),
      .ale_valid(ale_valid_s), .busy(busy_s), .overrun(overrun_s));

   typedef struct {
      logic [7:0]  r, g, b;
      logic [15:0] ir, ig, ib;
      int          at;
   } res_t;

   typedef struct {
      logic [23:0] bg, p1;
      int          pos1;
      logic [23:0] p2;
      int          pos2;
      bit          gaps;
      logic [7:0]  er, eg, eb;
      logic [15:0] eir, eig, eib;
   } vec_t;

   res_t res_q[$];
   vec_t vt[8];
   int   cyc = 0;
   int   last_at = 0;
   int   n_cmp = 0, n_bad = 0;
   int   small_pulses = 0;
   logic [7:0] small_ar = '0;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (ale_valid) res_q.push_back('{a_r, a_g, a_b, inv_a_r, inv_a_g, inv_a_b, cyc});
      if (ale_valid_s) begin
         small_pulses = small_pulses + 1;
         small_ar     = a_r_s;
      end
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; vld = 1'b0; vld_s = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         vld = 1'b0; vld_s = 1'b0;
      end
   endtask

   task automatic send_frame(input logic [23:0] bg, input logic [23:0] p1, input int pos1,
                             input logic [23:0] p2, input int pos2, input int npix, input bit gaps);
      int g;
      for (int i = 0; i < npix; i++) begin
         if (gaps) begin
            g = $urandom_range(0, 2);
            repeat (g) begin @(negedge clk); vld = 1'b0; end
         end
         @(negedge clk);
         pix = (i == pos1) ? p1 : ((i == pos2) ? p2 : bg);
         vld = 1'b1;
      end
      last_at = cyc + 1;
   endtask

   task automatic send_small(input logic [23:0] p1, input int pos1);
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         pix_s = (i == pos1) ? p1 : 24'h050505;
         vld_s = 1'b1;
      end
   endtask

   task automatic wait_results(input int n, input int budget, input string name);
      int k;
      k = 0;
      while ((res_q.size() < n) && (k < budget)) begin
         @(negedge clk);
         vld = 1'b0;
         k++;
      end
      check({name, "_pulses"}, res_q.size(), n);
   endtask

   logic [7:0]  b2b_r[3], b2b_g[3], b2b_b[3];
   logic [15:0] b2b_ir[3];

   initial begin
      rst = 1'b1; vld = 1'b0; pix = '0; vld_s = 1'b0; pix_s = '0;

      vt[0] = '{24'h101010, 24'hC8B4BE, 20, 24'h101010, -1, 1'b0, 8'd200, 8'd180, 8'd190, 16'd327, 16'd364, 16'd344};
      vt[1] = '{24'h101010, 24'hC8B4B9, 10, 24'hFABEB4, 40, 1'b0, 8'd200, 8'd180, 8'd185, 16'd327, 16'd364, 16'd354};
      vt[2] = '{24'h101010, 24'hC8B4B9, 10, 24'hFABEB4, 40, 1'b1, 8'd200, 8'd180, 8'd185, 16'd327, 16'd364, 16'd354};
      vt[3] = '{24'h000000, 24'h000000, -1, 24'h000000, -1, 1'b0, 8'd1, 8'd1, 8'd1, 16'd65535, 16'd65535, 16'd65535};
      vt[4] = '{24'h000000, 24'hFFFFFF, 63, 24'h000000, -1, 1'b0, 8'd255, 8'd255, 8'd255, 16'd257, 16'd257, 16'd257};
      vt[5] = '{24'h0A1405, 24'h323C46, 0, 24'h0A1405, -1, 1'b0, 8'd50, 8'd60, 8'd70, 16'd1310, 16'd1092, 16'd936};
      vt[6] = '{24'h030009, 24'h030009, -1, 24'h030009, -1, 1'b0, 8'd3, 8'd1, 8'd9, 16'd21845, 16'd65535, 16'd7281};
      vt[7] = '{24'h101010, 24'h646464, 5, 24'h656565, 6, 1'b0, 8'd101, 8'd101, 8'd101, 16'd648, 16'd648, 16'd648};

`ifdef ALE_IIR_EN
      b2b_r = '{8'd200, 8'd125, 8'd190}; b2b_g = '{8'd180, 8'd120, 8'd187};
      b2b_b = '{8'd190, 8'd130, 8'd192}; b2b_ir = '{16'd327, 16'd524, 16'd344};
`else
      b2b_r = '{8'd200, 8'd50, 8'd255}; b2b_g = '{8'd180, 8'd60, 8'd255};
      b2b_b = '{8'd190, 8'd70, 8'd255}; b2b_ir = '{16'd327, 16'd1310, 16'd257};
`endif

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_a_r", a_r, 0);         check("rst_a_g", a_g, 0);       check("rst_a_b", a_b, 0);
      check("rst_inv_r", inv_a_r, 0);   check("rst_inv_g", inv_a_g, 0); check("rst_inv_b", inv_a_b, 0);
      check("rst_valid", ale_valid, 0); check("rst_busy", busy, 0);     check("rst_overrun", overrun, 0);
      rst = 1'b0;

      // Single-frame vectors, each from a clean reset
      for (int v = 0; v < 8; v++) begin
         do_reset();
         res_q.delete();
         send_frame(vt[v].bg, vt[v].p1, vt[v].pos1, vt[v].p2, vt[v].pos2, 64, vt[v].gaps);
         idle(4);
         check($sformatf("v%0d_busy_mid", v), busy, 1);
         wait_results(1, 200, $sformatf("v%0d", v));
         if (res_q.size() > 0) begin
            check($sformatf("v%0d_a_r", v), res_q[0].r, vt[v].er);
            check($sformatf("v%0d_a_g", v), res_q[0].g, vt[v].eg);
            check($sformatf("v%0d_a_b", v), res_q[0].b, vt[v].eb);
            check($sformatf("v%0d_inv_r", v), res_q[0].ir, vt[v].eir);
            check($sformatf("v%0d_inv_g", v), res_q[0].ig, vt[v].eig);
            check($sformatf("v%0d_inv_b", v), res_q[0].ib, vt[v].eib);
            check($sformatf("v%0d_latency", v), res_q[0].at - last_at, LAT);
         end
         idle(2);
         check($sformatf("v%0d_busy_end", v), busy, 0);
         check($sformatf("v%0d_hold_a_r", v), a_r, vt[v].er);
         check($sformatf("v%0d_overrun", v), overrun, 0);
      end

      // Reset in the middle of a frame discards it
      do_reset();
      res_q.delete();
      send_frame(24'h101010, 24'hFFFFFF, 5, 24'h101010, -1, 30, 1'b0);
      do_reset();
      check("midrst_a_r", a_r, 0);
      send_frame(vt[0].bg, vt[0].p1, vt[0].pos1, vt[0].p2, vt[0].pos2, 64, 1'b0);
      wait_results(1, 200, "midrst");
      idle(20);
      check("midrst_only_one", res_q.size(), 1);
      if (res_q.size() > 0) begin
         check("midrst_a_r_val", res_q[0].r, 200);
         check("midrst_a_g_val", res_q[0].g, 180);
         check("midrst_inv_b", res_q[0].ib, 344);
      end
      check("midrst_overrun", overrun, 0);

      // Three back-to-back frames without idle gaps
      do_reset();
      res_q.delete();
      send_frame(vt[0].bg, vt[0].p1, vt[0].pos1, vt[0].p2, vt[0].pos2, 64, 1'b0);
      send_frame(vt[5].bg, vt[5].p1, vt[5].pos1, vt[5].p2, vt[5].pos2, 64, 1'b0);
      send_frame(vt[4].bg, vt[4].p1, vt[4].pos1, vt[4].p2, vt[4].pos2, 64, 1'b0);
      wait_results(3, 300, "b2b");
      for (int f = 0; f < 3; f++) begin
         if (res_q.size() > f) begin
            check($sformatf("b2b%0d_a_r", f), res_q[f].r, b2b_r[f]);
            check($sformatf("b2b%0d_a_g", f), res_q[f].g, b2b_g[f]);
            check($sformatf("b2b%0d_a_b", f), res_q[f].b, b2b_b[f]);
            check($sformatf("b2b%0d_inv_r", f), res_q[f].ir, b2b_ir[f]);
         end
      end
      if (res_q.size() > 2) check("b2b_last_latency", res_q[2].at - last_at, LAT);
      check("b2b_overrun", overrun, 0);

`ifdef ALE_IIR_EN
      // IIR smoothing with ALPHA_SHIFT=1: 200 then 200+((100-200)>>>1)=150
      do_reset();
      res_q.delete();
      send_frame(24'h000000, 24'hC8C8C8, 7, 24'h000000, -1, 64, 1'b0);
      wait_results(1, 200, "iir1");
      idle(10);
      send_frame(24'h000000, 24'h646464, 7, 24'h000000, -1, 64, 1'b0);
      wait_results(2, 200, "iir2");
      if (res_q.size() > 1) begin
         check("iir1_a_r", res_q[0].r, 200);
         check("iir1_inv_r", res_q[0].ir, 327);
         check("iir2_a_r", res_q[1].r, 150);
         check("iir2_inv_r", res_q[1].ir, 436);
      end
`endif

      // Non-compliant 4x4 frames: second frame ends mid-division and is dropped
      do_reset();
      check("small_overrun_rst", overrun_s, 0);
      small_pulses = 0;
      send_small(24'h646464, 3);
      send_small(24'hC8C8C8, 7);
      idle(200);
      check("small_pulses", small_pulses, 1);
      check("small_a_r", small_ar, 100);
      check("small_overrun", overrun_s, 1);
      check("small_inv_r", inv_a_r_s, 655);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/ale_stream_estimator.md
Name: ale_stream_estimator

Overview:
Parametrised, frame-streaming atmospheric-light estimator for the haze-removal pipeline. It replaces the fixed 8-bit ALE.
- Per frame, it finds the pixel whose minimum colour channel is largest and takes that pixel's RGB as A.
- It clamps A to a floor and computes per-channel reciprocals with a shared serial divider.
- It publishes A and 1/A to the transmission/recovery stages, one pulse per frame.
- Accumulation of the next frame overlaps the division of the current one.

Parameters:
DW, 8, bits per colour channel
INV_W, 16, reciprocal width; inv = floor((2^INV_W-1)/A)
IMG_W, 512, pixels per line
IMG_H, 512, lines per frame; NPIX=IMG_W*IMG_H must be >= 3*INV_W+4
A_MIN, 1, floor applied to each A channel (must be >=1)
ALPHA_SHIFT, 2, IIR smoothing shift (used only with ALE_IIR_EN)

Ports:
clk  in  1  rising-edge clock (single clock domain)
rst  in  1  synchronous, active-high reset
input_pixel  in  3*DW  [DW-1:0]=B, [2DW-1:DW]=G, [3DW-1:2DW]=R (BMP order)
input_is_valid  in  1  pixel qualifier; gaps allowed
a_r / a_g / a_b  out  DW each  atmospheric light per channel
inv_a_r / inv_a_g / inv_a_b  out  INV_W each  reciprocals
ale_valid  out  1  one-cycle pulse: all six outputs updated
busy  out  1  divider active
overrun  out  1  sticky: a frame result was dropped

Behaviour:
- Reset: every output is 0, the pixel counter is 0, the best-key register is 0, the FSM is in IDLE, and the IIR holds "no history". A reset mid-frame or mid-division discards all partial work.
- Accumulate runs independently of the FSM on every valid pixel:
  - key = min(R,G,B).
  - The first pixel of a frame loads best unconditionally.
  - Later pixels replace best only if key > best_key. Strict comparison: on a tie, the earliest pixel wins.
  - The counter counts valid pixels only and wraps to 0 after NPIX-1.
- Frame end is the valid pixel with count==NPIX-1. Its own candidacy is included. On the next edge:
  - the candidate is latched into cand_r/g/b with each channel clamped to max(ch, A_MIN);
  - accumulation restarts for the next frame.
- FSM states: IDLE -> (BLEND if ALE_IIR_EN) -> DIV_R -> DIV_G -> DIV_B -> DONE -> IDLE.
  - Each DIV state runs INV_W restoring-division iterations: numerator 2^INV_W-1, divisor the DW-bit A channel, one quotient bit per cycle MSB-first.
  - DONE drives ale_valid high for one cycle and returns to IDLE.
- Output timing:
  - a_* and inv_* registers update together, in the cycle ale_valid is high. They hold their values until the next pulse.
  - ale_valid rises exactly 3*INV_W+2 cycles after the edge that sampled the last pixel, +1 with ALE_IIR_EN.
  - busy is high from the first DIV cycle through DONE.
- Overrun: if a frame ends while the FSM is not IDLE, that candidate is dropped, overrun is set (cleared only by rst), and the in-flight result completes unaffected. This is unreachable when the NPIX constraint holds.
- Width rules:
  - The quotient saturates at 2^INV_W-1; A_MIN>=1 guarantees no divide-by-zero.
  - min, compare and clamp are unsigned DW-bit operations.

Optional Feature:
ALE_IIR_EN:
- Defined: a BLEND state produces A = A_prev + ((cand - A_prev) >>> ALPHA_SHIFT) per channel.
  - The subtraction is signed, DW+1 bits; the result is clamped to [A_MIN, 2^DW-1].
  - The first frame after reset loads cand directly.
- Undefined: A = cand, there is no BLEND state and no history register, and latency is 1 cycle shorter.

Decomposition:
- Package ale_pkg holds:
  - the FSM state enum (IDLE, BLEND, DIV_R, DIV_G, DIV_B, DONE);
  - channel slice offsets B/G/R;
  - the default DW/INV_W;
  - the function recip_num(INV_W)=2^INV_W-1.
- Sub-module ale_recip_div is the natural split: a serial restoring divider with start/divisor/busy/done/quotient, instantiated once and time-shared across the three channels.

Test Plan:
1. DW=8, INV_W=16, 8x8 frame; all pixels 0x101010 except one R=200,G=180,B=190 -> a=(200,180,190), inv=(327,364,344), ale_valid exactly 50 cycles after the last pixel.
2. Two pixels with equal key 180 (R=200 first, R=250 later) -> a_r=200 (first wins); a random valid-gap pattern gives the identical result.
3. All-black frame -> a=(1,1,1), inv=(65535,65535,65535).
4. rst asserted at pixel 30 of frame 1, then a full clean frame -> no ale_valid for the partial frame; the clean frame alone determines A; overrun=0.
5. Three back-to-back frames with no idle gaps -> three ale_valid pulses with per-frame values and no overrun. A non-compliant 4x4 frame configuration -> overrun=1 and the second result is dropped.
6. ALE_IIR_EN, ALPHA_SHIFT=1: frame1 candidate R=200, frame2 candidate R=100 -> a_r=200 then 150, inv_a_r=327 then 436.
